// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port RAM arbiter: FSM states, access direction and port ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } arb_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational 2-way round-robin choice: a lone requester wins, a tie goes to the port not granted last.
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic i_req_cpu,
  input  logic i_req_dma,
  input  logic i_last_grant,
  output logic o_valid_c,
  output logic o_port_c
);

  always_comb begin
    o_valid_c = i_req_cpu | i_req_dma;
    if (i_req_cpu && i_req_dma) begin
      o_port_c = ~i_last_grant;
    end else if (i_req_dma) begin
      o_port_c = PORT_DMA;
    end else begin
      o_port_c = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a processor port and a loader/DMA port onto one RAM; each access takes IDLE -> ISSUE -> COMPLETE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_rw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy,
  output logic              last_grant
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic       r_rw;
  logic       w_pick_valid;
  logic       w_pick_port;
  logic       w_latch;
  logic       w_finish;

  rr_picker u_picker (
    .i_req_cpu    (cpu_req),
    .i_req_dma    (dma_req),
    .i_last_grant (last_grant),
    .o_valid_c    (w_pick_valid),
    .o_port_c     (w_pick_port)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_next = ST_ISSUE;
          w_latch      = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_state_next = ST_COMPLETE;
        w_finish     = 1'b1;
      end
      ST_COMPLETE: w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // mem_* double as the latched request; mem_rw is high only for the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      mem_addr   <= '0;
      mem_in     <= '0;
      mem_rw     <= RW_READ;
      busy       <= 1'b0;
      last_grant <= PORT_DMA;
      r_rw       <= RW_READ;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      mem_rw  <= RW_READ;
      busy    <= (w_state_next != ST_IDLE);
      if (w_latch) begin
        last_grant <= w_pick_port;
        if (w_pick_port == PORT_DMA) begin
          r_rw     <= dma_rw;
          mem_rw   <= dma_rw;
          mem_addr <= dma_addr;
          mem_in   <= dma_wdata;
        end else begin
          r_rw     <= cpu_rw;
          mem_rw   <= cpu_rw;
          mem_addr <= cpu_addr;
          mem_in   <= cpu_wdata;
        end
      end
      if (w_finish) begin
        if (last_grant == PORT_CPU) begin
          cpu_ack <= 1'b1;
          if (r_rw == RW_READ) cpu_rdata <= mem_out;
        end else begin
          dma_ack <= 1'b1;
          if (r_rw == RW_READ) dma_rdata <= mem_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small RAM model (combinational read, write on clock edge).
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_rw = 1'b0;
  logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       dma_req = 1'b0, dma_rw = 1'b0;
  logic [7:0] dma_addr = 8'h00, dma_wdata = 8'h00;
  logic       dma_ack;
  logic [7:0] dma_rdata;
  logic [7:0] mem_addr, mem_in, mem_out;
  logic       mem_rw, busy, last_grant;
  logic [7:0] ram [256];

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_rw(mem_rw), .mem_out(mem_out),
    .busy(busy), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  // RAM: 0x10 is preloaded with 0xA5 whenever reset is applied.
  assign mem_out = ram[mem_addr];
  always @(posedge clk) begin
    if (rst) ram[8'h10] <= 8'hA5;
    else if (mem_rw) ram[mem_addr] <= mem_in;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_ack"},    32'(cpu_ack),    32'h0);
    chk({tag, "_dma_ack"},    32'(dma_ack),    32'h0);
    chk({tag, "_cpu_rdata"},  32'(cpu_rdata),  32'h0);
    chk({tag, "_dma_rdata"},  32'(dma_rdata),  32'h0);
    chk({tag, "_mem_addr"},   32'(mem_addr),   32'h0);
    chk({tag, "_mem_in"},     32'(mem_in),     32'h0);
    chk({tag, "_mem_rw"},     32'(mem_rw),     32'h0);
    chk({tag, "_busy"},       32'(busy),       32'h0);
    chk({tag, "_last_grant"}, 32'(last_grant), 32'h1);
  endtask

  initial begin
    logic exp_cpu_ack, exp_dma_ack;

    // Reset state
    tick();
    tick();
    check_reset_outputs("rst");

    // cpu read of preloaded 0x10
    rst = 1'b0;
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 8'h10;
    tick();
    chk("rd_issue_busy", 32'(busy), 32'h1);
    chk("rd_issue_addr", 32'(mem_addr), 32'h10);
    chk("rd_issue_rw", 32'(mem_rw), 32'h0);
    chk("rd_issue_ack", 32'(cpu_ack), 32'h0);
    chk("rd_issue_grant", 32'(last_grant), 32'h0);
    tick();
    chk("rd_cpu_ack", 32'(cpu_ack), 32'h1);
    chk("rd_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    chk("rd_dma_ack", 32'(dma_ack), 32'h0);
    cpu_req = 1'b0;
    tick();
    chk("rd_ack_pulse", 32'(cpu_ack), 32'h0);
    chk("rd_idle_busy", 32'(busy), 32'h0);
    chk("rd_rdata_hold", 32'(cpu_rdata), 32'hA5);

    // dma write 0x3C -> 0x20, request dropped during ISSUE
    dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 8'h20; dma_wdata = 8'h3C;
    tick();
    chk("wr_issue_rw", 32'(mem_rw), 32'h1);
    chk("wr_issue_addr", 32'(mem_addr), 32'h20);
    chk("wr_issue_data", 32'(mem_in), 32'h3C);
    chk("wr_issue_grant", 32'(last_grant), 32'h1);
    dma_req = 1'b0;
    tick();
    chk("wr_dma_ack", 32'(dma_ack), 32'h1);
    chk("wr_complete_rw", 32'(mem_rw), 32'h0);
    chk("wr_dma_rdata_keep", 32'(dma_rdata), 32'h0);
    chk("wr_cpu_rdata_keep", 32'(cpu_rdata), 32'hA5);
    chk("wr_hold_addr", 32'(mem_addr), 32'h20);
    tick();
    chk("wr_ack_pulse", 32'(dma_ack), 32'h0);
    chk("wr_idle_rw", 32'(mem_rw), 32'h0);

    // cpu reads back 0x20
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 8'h20;
    tick();
    chk("rb_issue_rw", 32'(mem_rw), 32'h0);
    tick();
    chk("rb_cpu_ack", 32'(cpu_ack), 32'h1);
    chk("rb_cpu_rdata", 32'(cpu_rdata), 32'h3C);
    cpu_req = 1'b0;
    tick();

    // Both requests held after reset: acks at cycles 2,5,8,11 alternating cpu,dma
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 8'h10;
    dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 8'h20;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_cpu_ack = (k == 2) || (k == 8);
      exp_dma_ack = (k == 5) || (k == 11);
      chk($sformatf("rr_cpu_ack_c%0d", k), 32'(cpu_ack), 32'(exp_cpu_ack));
      chk($sformatf("rr_dma_ack_c%0d", k), 32'(dma_ack), 32'(exp_dma_ack));
      if (k == 5) chk("rr_dma_rdata", 32'(dma_rdata), 32'h3C);
      if (k == 8) chk("rr_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    tick();
    chk("rr_end_busy", 32'(busy), 32'h0);

    // Reset hits the edge that would enter COMPLETE of a cpu read
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 8'h10;
    tick();
    chk("ab_issue_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    check_reset_outputs("ab");
    rst = 1'b0;
    cpu_req = 1'b0;
    tick();
    chk("ab_no_late_ack", 32'(cpu_ack), 32'h0);
    chk("ab_idle_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
